uart_rx_unit: RTL and testbench
===============================

# uart_rx_unit

Standalone UART receiver: recovers 8-bit frames from the serial line driven by the team's UART transmitter, using 16x oversampling of the 50 MHz system clock. Baud-rate and parity encodings match the duplex UART top. Outputs the received byte with active/done/error flags. It is the far-end loopback checker and the receive path of every UART instance in the design.

## Interface
- CLK_HZ, 50_000_000, system clock frequency used to derive the oversampling divisors.
- clock  in  1  system clock, 50 MHz, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_in  in  1  serial line, idle high, asynchronous to clock.
- baud_rate  in  2  00=2400, 01=4800, 10=9600, 11=19200 baud.
- parity_type  in  2  00=none, 01=odd, 10=even, 11=none.
- data_out  out  8  last received byte, LSB first on the line.
- rx_active_flag  out  1  high from start-edge detection until the frame ends or aborts.
- rx_done_flag  out  1  one-cycle pulse when a complete frame is received.
- error_flag  out  3  bit0 parity error, bit1 start-bit error, bit2 stop-bit error.

## Operation
- rx_in passes through a 2-flop synchronizer; all logic uses the synchronized value rxs.
- Tick generator: counter 0..DIV-1, 1-cycle tick at DIV-1. DIV = CLK_HZ/(baud*16), rounded to nearest: 1302, 651, 326, 163. Counter clears on start detection to align phase.
- baud_rate and parity_type are latched at start detection. Changes mid-frame are ignored.
- FSM states:
  - IDLE: rxs falling edge (1->0) -> START. Latch config, clear error_flag, set rx_active_flag.
  - START: at tick 8, sample rxs. If 0 -> DATA. If 1 -> set error_flag[1] and go to IDLE, with no done pulse and data_out unchanged.
  - DATA: sample every 16 ticks and shift in LSB first. After 8 bits -> PARITY if parity is enabled, else STOP.
  - PARITY: sample after 16 ticks. Odd: the ones count over data+parity must be odd; even: the count must be even. Mismatch sets error_flag[0].
  - STOP: sample after 16 ticks. If 0, set error_flag[2]. Then -> DONE.
  - DONE: one cycle. Update data_out, pulse rx_done_flag, clear rx_active_flag, then -> IDLE.
- On a parity or stop error the frame still completes: data_out updates and rx_done_flag pulses. error_flag holds until the next start detection or reset.
- IDLE requires rxs==1 before it arms. A line held low after a stop error does not retrigger until it returns high.

## Timing
- Reset values: data_out=8'h00, rx_active_flag=0, rx_done_flag=0, error_flag=3'b000, FSM=IDLE, tick counter=0. The synchronizer resets to 1.
- Input latency: 2 clocks (synchronizer) plus 1 clock (edge detect) from the rx_in fall to START entry.
- Sample points relative to start detection, in ticks:
  - start: 8
  - data bit k (k=0..7): 24+16k
  - parity: 152
  - stop: 168 with parity, 152 without
- rx_done_flag asserts 1 clock after the stop-bit sample.
- Example: 9600 baud with parity, 168*326 = 54768 clocks (~1.095 ms) from start detection to done.
- Back-to-back frames: a new start edge is accepted from the first IDLE cycle after DONE. The half-bit remainder of the stop bit is enough margin for a transmitter sending frames back to back.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). No partial data_out update.

## Test plan
- 9600 baud, odd parity, send 0xAA (correct parity bit = 1) -> rx_active_flag high for the frame, rx_done_flag pulses once, data_out=8'hAA, error_flag=000.
- 19200 baud, even parity, send 0x5C with the parity bit inverted -> data_out=8'h5C, error_flag=001, rx_done_flag pulses.
- 9600 baud, no parity (11), send 0x3C with stop bit driven 0 -> data_out=8'h3C, error_flag=100, done at tick 152 rather than 168.
- 2400 baud, 2 us low glitch on rx_in -> error_flag=010, no rx_done_flag, data_out unchanged, FSM back in IDLE.
- 4800 baud, even parity, frames 0x01 then 0xFE back to back -> two done pulses, data_out=01 then FE, error_flag=000 after each frame.
- Assert reset_n low during data bit 4 of a 0xAA frame, release, resend 0x55 -> outputs zero during reset, then data_out=8'h55, error_flag=000.

Source files
------------

// File: rtl/uart_rx_unit.sv
// Purpose: 16x-oversampling UART receiver, 8 data bits LSB first, optional odd/even parity, one stop bit.
// Latency: rx_done_flag rises 3 clocks + 168 ticks (152 without parity) after rx_in falls into the start bit.
// Backpressure: none; data_out and error_flag hold until the next frame overwrites them.
module uart_rx_unit #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx_in,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    output logic [7:0] data_out,
    output logic       rx_active_flag,
    output logic       rx_done_flag,
    output logic [2:0] error_flag
);
    localparam int DIV_2400  = (CLK_HZ + 2400 * 8) / (2400 * 16);
    localparam int DIV_4800  = (CLK_HZ + 4800 * 8) / (4800 * 16);
    localparam int DIV_9600  = (CLK_HZ + 9600 * 8) / (9600 * 16);
    localparam int DIV_19200 = (CLK_HZ + 19200 * 8) / (19200 * 16);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rx_meta;
    logic        rxs;
    logic        rxs_d;
    logic [1:0]  baud_q;
    logic [1:0]  par_q;
    logic [10:0] div_cnt;
    logic [10:0] div_last;
    logic        tick;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_q;
    logic        start_det;
    logic        bit_due;
    logic        par_en;
    logic        par_bad;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_comb begin
        case (baud_q)
            2'b00:   div_last = 11'(DIV_2400 - 1);
            2'b01:   div_last = 11'(DIV_4800 - 1);
            2'b10:   div_last = 11'(DIV_9600 - 1);
            default: div_last = 11'(DIV_19200 - 1);
        endcase
    end

    assign tick      = (div_cnt == div_last);
    // rxs_d must be high, so a line still low after a bad stop bit cannot retrigger
    assign start_det = (state == S_IDLE) && rxs_d && !rxs;
    // the start bit is sampled at its 8th tick (mid-bit), everything after every 16th
    assign bit_due   = tick && (tick_cnt == ((state == S_START) ? 4'd7 : 4'd15));
    assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
    assign par_bad   = (^{shift_q, rxs}) ^ (par_q == 2'b01);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_det) state_nxt = S_START;
            S_START:  if (bit_due) state_nxt = rxs ? S_IDLE : S_DATA;
            S_DATA:   if (bit_due && bit_cnt == 3'd7) state_nxt = par_en ? S_PARITY : S_STOP;
            S_PARITY: if (bit_due) state_nxt = S_STOP;
            S_STOP:   if (bit_due) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            baud_q     <= '0;
            par_q      <= '0;
            data_out   <= '0;
            error_flag <= '0;
        end else begin
            state <= state_nxt;

            // holding the divider at zero in IDLE phase-aligns ticks to the start edge
            if (state == S_IDLE || tick) div_cnt <= '0;
            else                         div_cnt <= div_cnt + 11'd1;

            if (state == S_IDLE)
                tick_cnt <= '0;
            else if (tick)
                tick_cnt <= (state == S_START && tick_cnt == 4'd7) ? 4'd0 : tick_cnt + 4'd1;

            if (state == S_IDLE) begin
                bit_cnt <= '0;
            end else if (state == S_DATA && bit_due) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift_q <= {rxs, shift_q[7:1]};
            end

            if (start_det) begin
                baud_q     <= baud_rate;
                par_q      <= parity_type;
                error_flag <= '0;
            end
            if (state == S_START && bit_due && rxs)       error_flag[1] <= 1'b1;
            if (state == S_PARITY && bit_due && par_bad)  error_flag[0] <= 1'b1;
            if (state == S_STOP && bit_due) begin
                data_out <= shift_q;
                if (!rxs) error_flag[2] <= 1'b1;
            end
        end
    end

    assign rx_done_flag   = (state == S_DONE);
    assign rx_active_flag = (state == S_START) || (state == S_DATA) ||
                            (state == S_PARITY) || (state == S_STOP);

endmodule

// File: tb/tb_uart_rx_unit.sv
// Serial frames are driven bit by bit from a behavioural transmitter; expected byte, error bits and
// done cycle are queued per frame and a monitor pops them on every rx_done_flag pulse.
`timescale 1ns/1ps
module tb_uart_rx_unit;
    localparam int CLK_HZ = 1_000_000;

    logic       clock;
    logic       reset_n;
    logic       rx_in;
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       rx_active_flag;
    logic       rx_done_flag;
    logic [2:0] error_flag;

    typedef struct {
        logic [7:0] data;
        logic [2:0] err;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       done_prev = 1'b0;
    logic [7:0] last_data = 8'h00;

    uart_rx_unit #(.CLK_HZ(CLK_HZ)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rx_in          (rx_in),
        .baud_rate      (baud_rate),
        .parity_type    (parity_type),
        .data_out       (data_out),
        .rx_active_flag (rx_active_flag),
        .rx_done_flag   (rx_done_flag),
        .error_flag     (error_flag)
    );

    initial clock = 1'b0;
    always #500 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic int div_of(input logic [1:0] br);
        int baud;
        baud = 2400 << br;
        return $rtoi(real'(CLK_HZ) / (baud * 16.0) + 0.5);
    endfunction

    // Drives one frame; abort_bit >= 0 pulls reset during that data bit and expects nothing.
    task automatic send_frame(input logic [7:0] b, input logic [1:0] br, input logic [1:0] pt,
                              input bit flip, input bit stop_v, input int abort_bit);
        int   div;
        int   bitc;
        int   ones;
        bit   pen;
        logic pb;
        exp_t e;
        div  = div_of(br);
        bitc = 16 * div;
        pen  = (pt == 2'b01) || (pt == 2'b10);
        pb   = (pt == 2'b01) ? ($countones(b) % 2 == 0) : ($countones(b) % 2 == 1);
        if (flip) pb = ~pb;
        ones   = $countones(b) + int'(pb);
        e.data = b;
        e.err  = {~stop_v, 1'b0, pen && ((pt == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1))};
        e.cyc  = cyc + 3 + (pen ? 168 : 152) * div;
        if (abort_bit < 0) exp_q.push_back(e);
        baud_rate   = br;
        parity_type = pt;
        rx_in       = 1'b0;
        wait_clks(4);
        baud_rate   = 2'($urandom);
        parity_type = 2'($urandom);
        wait_clks(bitc - 4);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            if (i == abort_bit) begin
                wait_clks(bitc / 2);
                reset_n = 1'b0;
                rx_in   = 1'b1;
                wait_clks(1);
                chk("rst_data", data_out, 8'h00);
                chk("rst_err", error_flag, 3'b000);
                chk("rst_active", rx_active_flag, 1'b0);
                chk("rst_done", rx_done_flag, 1'b0);
                wait_clks(3);
                reset_n   = 1'b1;
                last_data = 8'h00;
                return;
            end
            if (i == 4) chk("active_mid", rx_active_flag, 1'b1);
            wait_clks(bitc);
        end
        if (pen) begin
            rx_in = pb;
            wait_clks(bitc);
        end
        rx_in = stop_v;
        wait_clks(bitc);
        rx_in     = 1'b1;
        last_data = b;
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (rx_done_flag) begin
                chk("done_width", done_prev, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0 data_out=%0h", data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("data_out", data_out, mon_e.data);
                    chk("error_flag", error_flag, mon_e.err);
                    checks++;
                    if (cyc < mon_e.cyc || cyc > mon_e.cyc + 1) begin
                        errors++;
                        $display("FAIL done_cycle actual=%0d required=%0d", cyc, mon_e.cyc);
                    end
                end
            end
            done_prev = rx_done_flag;
        end else begin
            done_prev = 1'b0;
        end
    end

    initial begin
        #200_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         gap;
        logic [7:0] b;
        bit         stop_v;
        reset_n     = 1'b0;
        rx_in       = 1'b1;
        baud_rate   = 2'b00;
        parity_type = 2'b00;
        wait_clks(5);
        chk("reset_data", data_out, 8'h00);
        chk("reset_err", error_flag, 3'b000);
        chk("reset_active", rx_active_flag, 1'b0);
        chk("reset_done", rx_done_flag, 1'b0);
        reset_n = 1'b1;
        wait_clks(10);

        send_frame(8'hAA, 2'b10, 2'b01, 1'b0, 1'b1, -1);
        wait_clks(20);
        send_frame(8'h5C, 2'b11, 2'b10, 1'b1, 1'b1, -1);
        wait_clks(20);
        send_frame(8'h3C, 2'b10, 2'b11, 1'b0, 1'b0, -1);
        wait_clks(20);

        baud_rate   = 2'b00;
        parity_type = 2'b00;
        rx_in       = 1'b0;
        wait_clks(2);
        rx_in = 1'b1;
        wait_clks(4);
        chk("glitch_active", rx_active_flag, 1'b1);
        wait_clks(8 * div_of(2'b00) + 10);
        chk("glitch_err", error_flag, 3'b010);
        chk("glitch_data", data_out, last_data);
        chk("glitch_idle", rx_active_flag, 1'b0);
        wait_clks(20);

        send_frame(8'h01, 2'b01, 2'b10, 1'b0, 1'b1, -1);
        send_frame(8'hFE, 2'b01, 2'b10, 1'b0, 1'b1, -1);
        wait_clks(20);

        send_frame(8'hAA, 2'b10, 2'b01, 1'b0, 1'b1, 4);
        wait_clks(20);
        send_frame(8'h55, 2'b10, 2'b01, 1'b0, 1'b1, -1);
        wait_clks(20);

        for (int n = 0; n < 20; n++) begin
            b      = 8'($urandom);
            stop_v = ($urandom_range(0, 7) != 0);
            send_frame(b, 2'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0), stop_v, -1);
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 30);
            if (!stop_v && gap < 5) gap = 5;
            wait_clks(gap);
        end

        for (int t = 0; t < 2000 && exp_q.size() != 0; t++) wait_clks(1);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
